// File: rtl/dram_sched_pkg.sv
// Shared types and constants for the DRAM frame-buffer scheduler.
package dram_sched_pkg;

  localparam int unsigned ALIGN_BYTES = 128;
  localparam logic [31:0] ALIGN_MASK  = ~(32'(ALIGN_BYTES) - 32'd1);

  typedef enum logic [1:0] {
    FREE    = 2'd0,
    WRITING = 2'd1,
    READY   = 2'd2,
    HELD    = 2'd3
  } buf_state_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_REQ  = 2'd1,
    W_DROP = 2'd2,
    W_BUSY = 2'd3
  } wstate_t;

endpackage

// File: rtl/dram_buf_pick.sv
// Lowest-index FREE buffer priority encoder (purely combinational).
module dram_buf_pick #(
  parameter int NUM_BUFS = 3,
  parameter int IDX_W    = 3
) (
  input  logic [NUM_BUFS-1:0] free_i,
  output logic                found_o,
  output logic [IDX_W-1:0]    idx_o
);

  // Scan from the top down so the lowest free index wins.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int i = NUM_BUFS - 1; i >= 0; i--) begin
      if (free_i[i]) begin
        found_o = 1'b1;
        idx_o   = IDX_W'(i);
      end else begin
        found_o = found_o;
      end
    end
  end

endmodule

// File: rtl/dram_frame_sched.sv
// Frame-buffer scheduler: rotates DRAM frame buffers between the frame writer
// and a reader, publishing the newest complete frame.
// Optional statistics counters are built when DRAM_SCHED_STATS_EN is defined.
module dram_frame_sched
  import dram_sched_pkg::*;
#(
  parameter int NUM_BUFS = 3,
  parameter int IDX_W    = 3,
  parameter int FNUM_W   = 16
) (
  input  logic              fclk,
  input  logic              rst,
  input  logic              cfg_enable,
  input  logic [31:0]       cfg_base_addr,
  input  logic [31:0]       cfg_stride,
  input  logic [31:0]       cfg_frame_bytes,
  output logic              wr_frame_valid,
  input  logic              wr_frame_ready,
  output logic [31:0]       wr_BUF_ADDR,
  output logic [31:0]       wr_FRAME_BYTES,
  input  logic              rd_acq_valid,
  output logic              rd_acq_ready,
  output logic [31:0]       rd_addr,
  output logic [IDX_W-1:0]  rd_idx,
  output logic [FNUM_W-1:0] rd_frame_num,
  output logic              rd_held,
  input  logic              rd_release,
  output logic              busy,
  output logic [1:0]        debug_wstate,
  output logic [31:0]       stat_written,
  output logic [31:0]       stat_skipped
);

  wstate_t           wstate_q, wstate_d;
  buf_state_t        buf_q [NUM_BUFS];
  buf_state_t        buf_d [NUM_BUFS];
  logic              valid_q, valid_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       bytes_q, bytes_d;
  logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
  logic              rdy_vld_q, rdy_vld_d;
  logic [IDX_W-1:0]  rdy_idx_q, rdy_idx_d;
  logic [31:0]       rdy_addr_q, rdy_addr_d;
  logic [FNUM_W-1:0] rdy_fnum_q, rdy_fnum_d;
  logic [FNUM_W-1:0] fnum_q, fnum_d;
  logic              held_q, held_d;
  logic [IDX_W-1:0]  hidx_q, hidx_d;
  logic [31:0]       haddr_q, haddr_d;
  logic [FNUM_W-1:0] hfnum_q, hfnum_d;

  logic [NUM_BUFS-1:0] free_s;
  logic                found_s;
  logic [IDX_W-1:0]    pick_idx_s;
  logic                pick_go_s;
  logic                complete_s;
  logic                acquire_s;
  logic                release_s;
  logic                demote_s;
  logic [31:0]         pick_addr_s;

  // Gather the FREE flags for the priority encoder.
  always_comb begin
    for (int i = 0; i < NUM_BUFS; i++) begin
      free_s[i] = (buf_q[i] == FREE);
    end
  end

  dram_buf_pick #(.NUM_BUFS(NUM_BUFS), .IDX_W(IDX_W)) u_pick (
    .free_i  (free_s),
    .found_o (found_s),
    .idx_o   (pick_idx_s)
  );

  assign rd_acq_ready = rdy_vld_q && !held_q;
  assign pick_go_s    = (wstate_q == W_IDLE) && cfg_enable && found_s;
  assign complete_s   = (wstate_q == W_BUSY) && wr_frame_ready;
  assign acquire_s    = rd_acq_valid && rd_acq_ready;
  assign release_s    = rd_release && held_q;
  assign demote_s     = complete_s && rdy_vld_q && !acquire_s;
  assign pick_addr_s  = (cfg_base_addr + (32'(pick_idx_s) * cfg_stride)) & ALIGN_MASK;

  // Writer FSM next state and request latching.
  always_comb begin
    wstate_d = wstate_q;
    valid_d  = valid_q;
    addr_d   = addr_q;
    bytes_d  = bytes_q;
    wr_idx_d = wr_idx_q;
    case (wstate_q)
      W_IDLE: begin
        if (pick_go_s) begin
          addr_d   = pick_addr_s;
          bytes_d  = cfg_frame_bytes & ALIGN_MASK;
          wr_idx_d = pick_idx_s;
          valid_d  = 1'b1;
          wstate_d = W_REQ;
        end else begin
          wstate_d = W_IDLE;
        end
      end
      W_REQ: begin
        if (valid_q && wr_frame_ready) begin
          valid_d  = 1'b0;
          wstate_d = W_DROP;
        end else begin
          wstate_d = W_REQ;
        end
      end
      // The writer's ready lingers one cycle after accept; wait for it to fall.
      W_DROP: begin
        if (!wr_frame_ready) begin
          wstate_d = W_BUSY;
        end else begin
          wstate_d = W_DROP;
        end
      end
      W_BUSY: begin
        if (wr_frame_ready) begin
          wstate_d = W_IDLE;
        end else begin
          wstate_d = W_BUSY;
        end
      end
      default: begin
        wstate_d = W_IDLE;
        valid_d  = 1'b0;
      end
    endcase
  end

  // Buffer ownership, READY slot and reader hold bookkeeping.
  always_comb begin
    rdy_vld_d  = rdy_vld_q;
    rdy_idx_d  = rdy_idx_q;
    rdy_addr_d = rdy_addr_q;
    rdy_fnum_d = rdy_fnum_q;
    fnum_d     = fnum_q;
    held_d     = held_q;
    hidx_d     = hidx_q;
    haddr_d    = haddr_q;
    hfnum_d    = hfnum_q;
    if (acquire_s) begin
      held_d    = 1'b1;
      hidx_d    = rdy_idx_q;
      haddr_d   = rdy_addr_q;
      hfnum_d   = rdy_fnum_q;
      rdy_vld_d = 1'b0;
    end else if (release_s) begin
      held_d = 1'b0;
    end else begin
      held_d = held_q;
    end
    // A completion refills the READY slot even if the old one was just acquired.
    if (complete_s) begin
      rdy_vld_d  = 1'b1;
      rdy_idx_d  = wr_idx_q;
      rdy_addr_d = addr_q;
      rdy_fnum_d = fnum_q;
      fnum_d     = fnum_q + FNUM_W'(1);
    end else begin
      fnum_d = fnum_q;
    end
    for (int i = 0; i < NUM_BUFS; i++) begin
      buf_d[i] = buf_q[i];
      if (pick_go_s && (pick_idx_s == IDX_W'(i))) buf_d[i] = WRITING;
      else if (complete_s && (wr_idx_q == IDX_W'(i))) buf_d[i] = READY;
      else if (acquire_s && (rdy_idx_q == IDX_W'(i))) buf_d[i] = HELD;
      else if (demote_s && (rdy_idx_q == IDX_W'(i))) buf_d[i] = FREE;
      else if (release_s && (hidx_q == IDX_W'(i))) buf_d[i] = FREE;
      else buf_d[i] = buf_q[i];
    end
  end

  // State registers with synchronous reset; reset abandons any frame in flight.
  always_ff @(posedge fclk) begin
    if (rst) begin
      wstate_q   <= W_IDLE;
      valid_q    <= 1'b0;
      addr_q     <= 32'd0;
      bytes_q    <= 32'd0;
      wr_idx_q   <= '0;
      rdy_vld_q  <= 1'b0;
      rdy_idx_q  <= '0;
      rdy_addr_q <= 32'd0;
      rdy_fnum_q <= '0;
      fnum_q     <= '0;
      held_q     <= 1'b0;
      hidx_q     <= '0;
      haddr_q    <= 32'd0;
      hfnum_q    <= '0;
      for (int i = 0; i < NUM_BUFS; i++) buf_q[i] <= FREE;
    end else begin
      wstate_q   <= wstate_d;
      valid_q    <= valid_d;
      addr_q     <= addr_d;
      bytes_q    <= bytes_d;
      wr_idx_q   <= wr_idx_d;
      rdy_vld_q  <= rdy_vld_d;
      rdy_idx_q  <= rdy_idx_d;
      rdy_addr_q <= rdy_addr_d;
      rdy_fnum_q <= rdy_fnum_d;
      fnum_q     <= fnum_d;
      held_q     <= held_d;
      hidx_q     <= hidx_d;
      haddr_q    <= haddr_d;
      hfnum_q    <= hfnum_d;
      for (int i = 0; i < NUM_BUFS; i++) buf_q[i] <= buf_d[i];
    end
  end

  assign wr_frame_valid = valid_q;
  assign wr_BUF_ADDR    = addr_q;
  assign wr_FRAME_BYTES = bytes_q;
  assign rd_held        = held_q;
  assign rd_idx         = hidx_q;
  assign rd_addr        = haddr_q;
  assign rd_frame_num   = hfnum_q;
  assign busy           = (wstate_q != W_IDLE);
  assign debug_wstate   = wstate_q;

`ifdef DRAM_SCHED_STATS_EN
  logic [31:0] stat_written_q;
  logic [31:0] stat_skipped_q;

  // Saturating completion and unread-discard counters.
  always_ff @(posedge fclk) begin
    if (rst) begin
      stat_written_q <= 32'd0;
      stat_skipped_q <= 32'd0;
    end else begin
      if (complete_s && (stat_written_q != 32'hFFFF_FFFF)) stat_written_q <= stat_written_q + 32'd1;
      if (demote_s && (stat_skipped_q != 32'hFFFF_FFFF)) stat_skipped_q <= stat_skipped_q + 32'd1;
    end
  end

  assign stat_written = stat_written_q;
  assign stat_skipped = stat_skipped_q;
`else
  assign stat_written = 32'd0;
  assign stat_skipped = 32'd0;
`endif

endmodule
